// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register write scoreboard sitting beside the ID stage. It tracks
//   in-flight writes of variable latency and produces stall, bubble and flush
//   controls for PC/IF/ID/EX. It covers RAW against multi-cycle results (with
//   a forwarding window), WAW against out-of-order completion and conflicts on
//   the single write-back port. It also handles branch flush, a global freeze,
//   and keeps a saturating count of hazard-stall cycles.
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   id_valid                     ID holds a valid instruction
//   id_rs1/_used, id_rs2/_used   source indices and read enables
//   id_rd, id_reg_write          destination index and write enable
//   id_lat                       result latency in cycles (0 is treated as 1)
//   branch_taken                 branch resolved taken in EX
//   freeze                       global pipeline freeze
//   pc_stall, if_stall, id_stall hold controls
//   ex_bubble                    inject NOP into ID/EX
//   if_flush, id_flush           squash controls
//   issue                        ID instruction advances this cycle
//   busy_vec                     per-register pending-write flags
//   stall_count                  saturating hazard-stall cycle count
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LAT_W    = 3,
  parameter int FWD_DIST = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic                id_rs1_used,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_rs2_used,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_reg_write,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                branch_taken,
  input  logic                freeze,
  output logic                pc_stall,
  output logic                if_stall,
  output logic                id_stall,
  output logic                ex_bubble,
  output logic                if_flush,
  output logic                id_flush,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    stall_count
);

  // A forwarding distance at or beyond the largest count means a source is
  // always ready, so clamp it into the counter range.
  localparam int FWD_MAX = (1 << LAT_W) - 1;
  localparam int FWD_CLAMP = (FWD_DIST > FWD_MAX) ? FWD_MAX : FWD_DIST;
  localparam logic [LAT_W-1:0] FWD_LIM = LAT_W'(FWD_CLAMP);

  logic [NUM_REGS-1:0] r_busy;
  logic [LAT_W-1:0]    r_cnt [NUM_REGS];
  logic [CNT_W-1:0]    r_stall_count;

  logic [LAT_W-1:0] w_lat;
  logic [LAT_W:0]   w_lat_p1;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_wbc;
  logic             w_port_busy;
  logic             w_haz;
  logic             w_haz_stall;
  logic             w_rd_live;

  assign w_lat    = (id_lat == '0) ? LAT_W'(1) : id_lat;
  // One bit wider so that L+1 never wraps onto a small count.
  assign w_lat_p1 = {1'b0, w_lat} + (LAT_W+1)'(1);

  assign w_rd_live = id_valid & id_reg_write & (id_rd != '0);

  assign w_raw1 = id_valid & id_rs1_used & (id_rs1 != '0) & r_busy[id_rs1]
                & (r_cnt[id_rs1] > FWD_LIM);
  assign w_raw2 = id_valid & id_rs2_used & (id_rs2 != '0) & r_busy[id_rs2]
                & (r_cnt[id_rs2] > FWD_LIM);
  // An older write still finishing after ours would overwrite our result.
  assign w_waw  = w_rd_live & r_busy[id_rd] & ({1'b0, r_cnt[id_rd]} >= w_lat_p1);

  // Our write-back would land in the same cycle as some pending write.
  always_comb begin
    w_port_busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (r_busy[r] && ({1'b0, r_cnt[r]} == w_lat_p1)) w_port_busy = 1'b1;
    end
  end
  assign w_wbc = w_rd_live & w_port_busy;

  assign w_haz       = w_raw1 | w_raw2 | w_waw | w_wbc;
  assign w_haz_stall = ~freeze & ~branch_taken & w_haz;

  always_comb begin
    pc_stall  = 1'b0;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_bubble = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    issue     = 1'b0;
    if (freeze) begin
      pc_stall = 1'b1;
      if_stall = 1'b1;
      id_stall = 1'b1;
    end else if (branch_taken) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (w_haz) begin
      pc_stall  = 1'b1;
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_bubble = 1'b1;
    end else begin
      issue = id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy        <= '0;
      r_cnt         <= '{default: '0};
      r_stall_count <= '0;
    end else if (!freeze) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (r_busy[r]) begin
          r_cnt[r] <= r_cnt[r] - LAT_W'(1);
          if (r_cnt[r] == LAT_W'(1)) r_busy[r] <= 1'b0;
        end
      end
      // Placed after the decrement loop so a new issue wins over a
      // same-edge write-back of the same register.
      if (issue && id_reg_write && (id_rd != '0)) begin
        r_busy[id_rd] <= 1'b1;
        r_cnt[id_rd]  <= w_lat;
      end
      if (w_haz_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign busy_vec    = r_busy;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard. Three instances share one stimulus
//   stream: default parameters, FWD_DIST=0, and CNT_W=4. Each stimulus cycle
//   may push a hand-computed expectation (tagged with the instance to look at)
//   into a queue; a monitor on the falling edge pops and compares.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic       id_rs1_used;
  logic [4:0] id_rs2;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic [2:0] id_lat;
  logic       branch_taken;
  logic       freeze;

  // ctrl bit order: pc_stall, if_stall, id_stall, ex_bubble, if_flush, id_flush, issue
  logic [6:0]  c_a, c_b, c_c;
  logic [31:0] b_a, b_b, b_c;
  logic [15:0] s_a, s_b;
  logic [3:0]  s_c;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_ISSUE = 7'b0000001;
  localparam logic [6:0] C_STALL = 7'b1111000;
  localparam logic [6:0] C_FRZ   = 7'b1110000;
  localparam logic [6:0] C_FLUSH = 7'b0000110;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
    .branch_taken(branch_taken), .freeze(freeze),
    .pc_stall(c_a[6]), .if_stall(c_a[5]), .id_stall(c_a[4]), .ex_bubble(c_a[3]),
    .if_flush(c_a[2]), .id_flush(c_a[1]), .issue(c_a[0]),
    .busy_vec(b_a), .stall_count(s_a)
  );

  hazard_scoreboard #(.FWD_DIST(0)) u_dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
    .branch_taken(branch_taken), .freeze(freeze),
    .pc_stall(c_b[6]), .if_stall(c_b[5]), .id_stall(c_b[4]), .ex_bubble(c_b[3]),
    .if_flush(c_b[2]), .id_flush(c_b[1]), .issue(c_b[0]),
    .busy_vec(b_b), .stall_count(s_b)
  );

  hazard_scoreboard #(.CNT_W(4)) u_dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
    .branch_taken(branch_taken), .freeze(freeze),
    .pc_stall(c_c[6]), .if_stall(c_c[5]), .id_stall(c_c[4]), .ex_bubble(c_c[3]),
    .if_flush(c_c[2]), .id_flush(c_c[1]), .issue(c_c[0]),
    .busy_vec(b_c), .stall_count(s_c)
  );

  typedef struct {
    int          sel;
    logic [6:0]  ctrl;
    logic [31:0] busy;
    logic [15:0] sc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t        m_e;
  logic [6:0]  m_c;
  logic [31:0] m_b;
  logic [15:0] m_s;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      case (m_e.sel)
        1:       begin m_c = c_b; m_b = b_b; m_s = s_b; end
        2:       begin m_c = c_c; m_b = b_c; m_s = {12'd0, s_c}; end
        default: begin m_c = c_a; m_b = b_a; m_s = s_a; end
      endcase
      n_checks++;
      if (m_c !== m_e.ctrl || m_b !== m_e.busy || m_s !== m_e.sc) begin
        n_fail++;
        $display("FAIL %s: got ctrl=%b busy=%h sc=%0d, want ctrl=%b busy=%h sc=%0d",
                 m_e.name, m_c, m_b, m_s, m_e.ctrl, m_e.busy, m_e.sc);
      end
    end
  end

  task automatic cyc(input int sel, input logic v,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic rw, input logic [2:0] lat,
                     input logic br, input logic frz, input logic r,
                     input logic chk, input logic [6:0] ec,
                     input logic [31:0] eb, input logic [15:0] es,
                     input string nm);
    exp_t x;
    id_valid     = v;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_lat       = lat;
    branch_taken = br;
    freeze       = frz;
    rst          = r;
    if (chk) begin
      x.sel  = sel;
      x.ctrl = ec;
      x.busy = eb;
      x.sc   = es;
      x.name = nm;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int sel, input logic [31:0] eb, input logic [15:0] es,
                      input string nm);
    cyc(sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, eb, es, nm);
  endtask

  task automatic do_rst();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0, "");
  endtask

  function automatic logic [15:0] sat15(input int n);
    return (n > 15) ? 16'd15 : 16'(n);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs1_used = 1'b0;
    id_rs2 = '0; id_rs2_used = 1'b0; id_rd = '0; id_reg_write = 1'b0;
    id_lat = '0; branch_taken = 1'b0; freeze = 1'b0;
    @(posedge clk);
    #1;

    // reset then idle
    do_rst();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 0, 0, "rst_hold");
    idle(0, 0, 0, "idle_after_rst");

    // ALU result forwarded, no stall
    cyc(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, C_ISSUE, 0,        0, "alu_prod");
    cyc(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_ISSUE, 32'h20,   0, "alu_fwd");
    idle(0, 0, 0, "alu_wb_done");

    // load-use, FWD_DIST=1: one stall
    cyc(0, 1, 0, 0, 0, 0, 3, 1, 2, 0, 0, 0, 1, C_ISSUE, 0,        0, "ld_prod");
    cyc(0, 1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 1, C_STALL, 32'h8,    0, "ld_use_stall");
    cyc(0, 1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 1, C_ISSUE, 32'h8,    1, "ld_use_issue");
    idle(0, 0, 1, "ld_after");

    // load-use, FWD_DIST=0: two stalls
    do_rst();
    cyc(1, 1, 0, 0, 0, 0, 3, 1, 2, 0, 0, 0, 1, C_ISSUE, 0,        0, "f0_prod");
    cyc(1, 1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 1, C_STALL, 32'h8,    0, "f0_stall1");
    cyc(1, 1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 1, C_STALL, 32'h8,    1, "f0_stall2");
    cyc(1, 1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 1, C_ISSUE, 0,        2, "f0_issue");

    // write-back port conflict: x7 L=4 then x8 L=3
    do_rst();
    cyc(0, 1, 0, 0, 0, 0, 7, 1, 4, 0, 0, 0, 1, C_ISSUE, 0,        0, "wbc_prod");
    cyc(0, 1, 0, 0, 0, 0, 8, 1, 3, 0, 0, 0, 1, C_STALL, 32'h80,   0, "wbc_stall");
    cyc(0, 1, 0, 0, 0, 0, 8, 1, 3, 0, 0, 0, 1, C_ISSUE, 32'h80,   1, "wbc_issue");
    idle(0, 32'h180, 1, "wbc_both1");
    idle(0, 32'h180, 1, "wbc_both2");
    idle(0, 32'h100, 1, "wbc_x7_done");
    idle(0, 0,       1, "wbc_x8_done");

    // WAW: x9 L=4 then x9 L=1; stalls while cnt[9] >= 2 (cnt 4,3,2)
    do_rst();
    cyc(0, 1, 0, 0, 0, 0, 9, 1, 4, 0, 0, 0, 1, C_ISSUE, 0,        0, "waw_prod");
    cyc(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, C_STALL, 32'h200,  0, "waw_stall1");
    cyc(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, C_STALL, 32'h200,  1, "waw_stall2");
    cyc(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, C_STALL, 32'h200,  2, "waw_stall3");
    cyc(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, C_ISSUE, 32'h200,  3, "waw_issue");
    idle(0, 32'h200, 3, "waw_reissued");
    idle(0, 0,       3, "waw_done");

    // branch during a load-use stall
    do_rst();
    cyc(0, 1, 0, 0, 0, 0, 3, 1, 3, 0, 0, 0, 1, C_ISSUE, 0,        0, "br_prod");
    cyc(0, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_STALL, 32'h8,    0, "br_stall");
    cyc(0, 1, 3, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, C_FLUSH, 32'h8,    1, "br_flush");
    idle(0, 32'h8, 1, "br_after");
    idle(0, 0,     1, "br_wb");

    // x0 never tracked and never stalls
    cyc(0, 1, 0, 1, 0, 1, 0, 1, 7, 0, 0, 0, 1, C_ISSUE, 0,        1, "x0_issue");
    idle(0, 0, 1, "x0_untracked");

    // freeze holds the counter; reset discards a pending write
    do_rst();
    cyc(0, 1, 0, 0, 0, 0, 4, 1, 7, 0, 0, 0, 1, C_ISSUE, 0,        0, "frz_prod");
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 4, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, C_FRZ, 32'h10,   0, "frz_cycle");
    end
    // L=6 conflicts on the port only if cnt[4] is still 7
    cyc(0, 1, 0, 0, 0, 0, 10, 1, 6, 0, 0, 0, 1, C_STALL, 32'h10,  0, "frz_held");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 32'h10,    1, "rst_midflight");
    idle(0, 0, 0, "rst_cleared");

    // stall_count saturation with CNT_W=4: 3 rounds of (issue, 6 stalls)
    do_rst();
    for (int r = 0; r < 3; r++) begin
      cyc(2, 1, 12, 1, 0, 0, 12, 1, 7, 0, 0, 0, 1, C_ISSUE,
          (r == 0) ? 32'h0 : 32'h1000, sat15(r * 6), "sat_issue");
      for (int j = 0; j < 6; j++) begin
        cyc(2, 1, 12, 1, 0, 0, 12, 1, 7, 0, 0, 0, 1, C_STALL,
            32'h1000, sat15(r * 6 + j), "sat_stall");
      end
    end
    idle(2, 32'h1000, 16'd15, "sat_hold");

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
